// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one iterative 130x128 limb multiplier among NUM_REQ requesters.
//   A round-robin pick captures the winner's operands, pulses m_start, waits
//   for m_done and returns the 258-bit product to the owning requester. Only
//   one job is ever in flight.
//
//   Optional feature: define MULT_ARB_TIMEOUT_EN to add a 16-bit WAIT-state
//   watchdog of TIMEOUT_CYCLES cycles. On expiry, the owner gets a zero product
//   together with a timeout_err pulse. Without the macro there is no counter,
//   WAIT lasts until m_done, and timeout_err is tied low.
//
// Ports
//   clk, reset   : single clock, synchronous active-high reset
//   req          : level request per requester. Operands are held stable until gnt.
//   req_a/req_b  : operands. Requester i uses [i*130 +: 130] / [i*128 +: 128].
//   gnt          : one-hot pulse; the operands of that requester have been captured
//   rsp_valid    : one-hot pulse; rsp_data belongs to that requester
//   rsp_data     : product, held until the next rsp_valid
//   m_start      : start pulse to the multiplier
//   m_a/m_b      : multiplier operands, stable from m_start until the next grant
//   m_busy       : multiplier busy; blocks new grants
//   m_done       : multiplier done pulse; m_product is valid in that cycle
//   m_product    : multiplier result
//   timeout_err  : watchdog expiry pulse
module mult_share_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*130-1:0] req_a,
  input  logic [NUM_REQ*128-1:0] req_b,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [257:0]           rsp_data,
  output logic                   m_start,
  output logic [129:0]           m_a,
  output logic [127:0]           m_b,
  input  logic                   m_busy,
  input  logic                   m_done,
  input  logic [257:0]           m_product,
  output logic                   timeout_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
    $error("mult_share_arbiter: parameter out of range");
  end

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               state, state_n;
  logic [PTR_W-1:0]     rr_ptr, rr_n;
  logic [PTR_W-1:0]     owner, owner_n;
  logic [NUM_REQ-1:0]   gnt_n, rsp_valid_n;
  logic                 m_start_n;
  logic [129:0]         m_a_n;
  logic [127:0]         m_b_n;
  logic [257:0]         rsp_data_n;

  logic                 pick_vld;
  logic [PTR_W-1:0]     pick_idx;
  int                   scan;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt, cnt_n;
  logic        tmo_n;
`endif

  // Round-robin pick. The scan starts one past the last winner and wraps, so
  // the last winner is considered last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!pick_vld && req[scan[PTR_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan[PTR_W-1:0];
      end
    end
  end

  // Next-state and next-output logic. Every output is a flop that loads its _n value.
  always_comb begin
    state_n     = state;
    rr_n        = rr_ptr;
    owner_n     = owner;
    gnt_n       = '0;
    rsp_valid_n = '0;
    m_start_n   = 1'b0;
    m_a_n       = m_a;
    m_b_n       = m_b;
    rsp_data_n  = rsp_data;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_n       = cnt;
    tmo_n       = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // m_busy also covers a multiplier still running after an arbiter-only
        // reset. A stale m_done seen here is ignored.
        if (pick_vld && !m_busy) begin
          gnt_n[pick_idx] = 1'b1;
          m_start_n       = 1'b1;
          m_a_n           = req_a[int'(pick_idx)*130 +: 130];
          m_b_n           = req_b[int'(pick_idx)*128 +: 128];
          owner_n         = pick_idx;
          rr_n            = pick_idx;
          state_n         = S_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
          cnt_n           = '0;
`endif
        end
      end
      S_WAIT: begin
        // When m_done coincides with watchdog expiry, the real result wins.
        if (m_done) begin
          rsp_valid_n[owner] = 1'b1;
          rsp_data_n         = m_product;
          state_n            = S_IDLE;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (cnt == TMO_LIM) begin
          rsp_valid_n[owner] = 1'b1;
          rsp_data_n         = '0;
          tmo_n              = 1'b1;
          state_n            = S_IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= PTR_W'(NUM_REQ - 1);
      owner     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      m_start   <= 1'b0;
      m_a       <= '0;
      m_b       <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      owner     <= owner_n;
      gnt       <= gnt_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      m_start   <= m_start_n;
      m_a       <= m_a_n;
      m_b       <= m_b_n;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      timeout_err <= tmo_n;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
